reg_writeback_stage: RTL
========================

Name: reg_writeback_stage

Overview:
Parametrised successor to the combinational register write-back stage. It adds a registered MA->WB pipeline stage with stall support and a second write source for long-latency units (divider, multi-cycle ops). That second source is buffered in a small FIFO and merged onto the single register-file write port when the pipeline leaves a free slot. The block sits between the memory-access stage and the register file and also provides a retired-write counter.

Parameters:
DATA_W, 16, data width of results, load data and RF write data
IDX_W, 5, register index width
CTRL_W, 5, width of the MA control/opcode field
LOAD_OP, 5'b01100, CTRL_MA value selecting DATA_MA over RES_MA
AUX_DEPTH, 2, aux write FIFO entries (power of two, >=2)
ZERO_REG_EN, 1, 1 = writes to index 0 are suppressed
CNT_W, 32, width of retired-write counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
STALL_WB  in  1  pipeline stall; MA inputs are not accepted while high
VALID_MA  in  1  MA stage holds a valid instruction
DEST_REG_INDEX_MA  in  IDX_W  destination register
DEST_REG_WRITE_EN_MA  in  1  instruction writes a register
RES_MA  in  DATA_W  ALU result
DATA_MA  in  DATA_W  load data
CTRL_MA  in  CTRL_W  opcode/control
AUX_VALID  in  1  aux unit presents a result
AUX_READY  out  1  FIFO can accept (count < AUX_DEPTH)
AUX_INDEX  in  IDX_W  aux destination register
AUX_DATA  in  DATA_W  aux result
WRITE_INDEX_RF  out  IDX_W  RF write index (registered)
WRITE_DATA_RF  out  DATA_W  RF write data (registered)
WRITE_EN_RF  out  1  RF write enable (registered)
AUX_COUNT  out  clog2(AUX_DEPTH)+1  FIFO occupancy
RETIRED_CNT  out  CNT_W  number of cycles with WRITE_EN_RF=1 since reset

Behaviour:
- Reset (rst=1 at a clock edge): WRITE_EN_RF=0, WRITE_INDEX_RF=0, WRITE_DATA_RF=0, FIFO emptied (AUX_COUNT=0, AUX_READY=1), RETIRED_CNT=0. A reset mid-operation discards buffered aux entries and any in-flight write.
- Pipeline candidate (combinational): pw = VALID_MA & DEST_REG_WRITE_EN_MA & !STALL_WB & !(ZERO_REG_EN & DEST_REG_INDEX_MA==0). Data = (CTRL_MA==LOAD_OP) ? DATA_MA : RES_MA. Full CTRL_W-bit compare.
- Aux push: when AUX_VALID & AUX_READY. AUX_READY depends only on the registered count, with no combinational path from AUX_VALID. If ZERO_REG_EN and AUX_INDEX==0, the handshake completes and the entry is discarded (not pushed).
- Output register, each non-reset edge, in priority order:
  - pw=1: load pipeline index/data and set WRITE_EN_RF=1. FIFO is not popped.
  - else FIFO non-empty: load head index/data, set WRITE_EN_RF=1, pop.
  - else WRITE_EN_RF=0. Index/data hold their previous values.
- Latency: MA -> RF port is exactly 1 cycle. Aux push -> RF port is at least 2 cycles; there is no bypass around the FIFO, even when it is empty.
- STALL_WB=1 blocks only the pipeline source. The FIFO drains during stalls.
- Simultaneous push and pop in one cycle: count unchanged. Push is allowed only if count<AUX_DEPTH before the edge; a pop in the same cycle does not make room. Pointers wrap modulo AUX_DEPTH.
- Full: AUX_READY=0, and AUX_VALID is ignored. Empty: no pop and no aux write.
- Aux entries write in FIFO order. WAW ordering between aux and pipeline writes to the same index is the issue scoreboard's responsibility, not this block's.
- RETIRED_CNT increments by 1 on each edge that sets WRITE_EN_RF=1 and wraps at 2^CNT_W.

Test Plan:
- Load select: VALID_MA=1, WE=1, idx=3, CTRL_MA=5'b01100, DATA_MA=16'hBEEF, RES_MA=16'h1234 -> next cycle WRITE_EN_RF=1, idx 3, data BEEF. Repeat with CTRL_MA=0 -> data 1234.
- Zero-reg suppression: pipeline write to idx 0 -> WRITE_EN_RF=0 next cycle, RETIRED_CNT unchanged. Aux push idx 0 -> accepted, AUX_COUNT stays 0, no RF write.
- Aux merge: continuous pipeline writes for 4 cycles while aux pushes idx 7=0x0A then idx 8=0x0B. Expected: AUX_COUNT=2 and AUX_READY=0; the third AUX_VALID is not accepted. Drop VALID_MA -> RF writes 7/0x0A then 8/0x0B on consecutive cycles, AUX_COUNT returns to 0.
- Stall drain: 1 aux entry buffered, STALL_WB=1 with VALID_MA=1 -> aux entry written next cycle, pipeline write absent until the stall releases.
- Simultaneous push/pop at count=1 with no pipeline write -> count stays 1, head written, new entry retained. Wrap check: 5 push/pop cycles return correct data in order.
- Reset mid-operation: FIFO holding 2 entries, assert rst one cycle -> WRITE_EN_RF=0, AUX_COUNT=0, RETIRED_CNT=0, and no buffered entry is ever written.

Source files
------------

// File: rtl/reg_writeback_stage_if.sv
// MA-stage, aux-unit and register-file write-port bundle for reg_writeback_stage.
// master = upstream/test driver, slave = the write-back stage itself.
interface reg_writeback_stage_if #(
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 5,
  parameter int CTRL_W    = 5,
  parameter int AUX_DEPTH = 2,
  parameter int CNT_W     = 32
);
  logic                          STALL_WB;
  logic                          VALID_MA;
  logic [IDX_W-1:0]              DEST_REG_INDEX_MA;
  logic                          DEST_REG_WRITE_EN_MA;
  logic [DATA_W-1:0]             RES_MA;
  logic [DATA_W-1:0]             DATA_MA;
  logic [CTRL_W-1:0]             CTRL_MA;
  logic                          AUX_VALID;
  logic                          AUX_READY;
  logic [IDX_W-1:0]              AUX_INDEX;
  logic [DATA_W-1:0]             AUX_DATA;
  logic [IDX_W-1:0]              WRITE_INDEX_RF;
  logic [DATA_W-1:0]             WRITE_DATA_RF;
  logic                          WRITE_EN_RF;
  logic [$clog2(AUX_DEPTH):0]    AUX_COUNT;
  logic [CNT_W-1:0]              RETIRED_CNT;

  modport master (
    output STALL_WB, VALID_MA, DEST_REG_INDEX_MA, DEST_REG_WRITE_EN_MA,
           RES_MA, DATA_MA, CTRL_MA, AUX_VALID, AUX_INDEX, AUX_DATA,
    input  AUX_READY, WRITE_INDEX_RF, WRITE_DATA_RF, WRITE_EN_RF,
           AUX_COUNT, RETIRED_CNT
  );

  modport slave (
    input  STALL_WB, VALID_MA, DEST_REG_INDEX_MA, DEST_REG_WRITE_EN_MA,
           RES_MA, DATA_MA, CTRL_MA, AUX_VALID, AUX_INDEX, AUX_DATA,
    output AUX_READY, WRITE_INDEX_RF, WRITE_DATA_RF, WRITE_EN_RF,
           AUX_COUNT, RETIRED_CNT
  );
endinterface

// File: rtl/reg_writeback_stage.sv
// Registered MA->WB write-back merging a buffered aux source; MA->RF 1 cycle, aux->RF >= 2 cycles.
// Pipeline writes win the RF port; aux FIFO drains in free slots (also during stall); AUX_READY=0 when full.
module reg_writeback_stage #(
  parameter int                DATA_W      = 16,
  parameter int                IDX_W       = 5,
  parameter int                CTRL_W      = 5,
  parameter logic [CTRL_W-1:0] LOAD_OP     = CTRL_W'(5'b01100),
  parameter int                AUX_DEPTH   = 2,
  parameter bit                ZERO_REG_EN = 1'b1,
  parameter int                CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_writeback_stage_if.slave  bus
);

  localparam int                PTR_W   = $clog2(AUX_DEPTH);
  localparam int                CNT_AW  = PTR_W + 1;
  localparam logic [CNT_AW-1:0] DEPTH_C = CNT_AW'(AUX_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] dat;
  } aux_ent_t;

  aux_ent_t            mem_q [AUX_DEPTH];
  aux_ent_t            mem_d [AUX_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_AW-1:0]   cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic                aux_rdy;
  logic                aux_push;
  logic                aux_pop;
  logic                pipe_wr;
  logic [DATA_W-1:0]   pipe_dat;

  always_comb begin
    aux_rdy  = (cnt_q < DEPTH_C);
    pipe_wr  = bus.VALID_MA && bus.DEST_REG_WRITE_EN_MA && !bus.STALL_WB &&
               !(ZERO_REG_EN && (bus.DEST_REG_INDEX_MA == '0));
    pipe_dat = (bus.CTRL_MA == LOAD_OP) ? bus.DATA_MA : bus.RES_MA;
    // Index-0 aux results complete the handshake but are dropped here.
    aux_push = bus.AUX_VALID && aux_rdy &&
               !(ZERO_REG_EN && (bus.AUX_INDEX == '0));
    aux_pop  = !pipe_wr && (cnt_q != '0);

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q + CNT_AW'(aux_push) - CNT_AW'(aux_pop);
    wr_en_d  = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_dat_d = wr_dat_q;

    if (aux_push) begin
      mem_d[wr_ptr_q] = '{idx: bus.AUX_INDEX, dat: bus.AUX_DATA};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pipe_wr) begin
      wr_en_d  = 1'b1;
      wr_idx_d = bus.DEST_REG_INDEX_MA;
      wr_dat_d = pipe_dat;
    end else if (aux_pop) begin
      wr_en_d  = 1'b1;
      wr_idx_d = mem_q[rd_ptr_q].idx;
      wr_dat_d = mem_q[rd_ptr_q].dat;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    retired_d = wr_en_d ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_dat_q  <= '0;
      retired_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_dat_q  <= wr_dat_d;
      retired_q <= retired_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.AUX_READY      = aux_rdy;
  assign bus.AUX_COUNT      = cnt_q;
  assign bus.WRITE_EN_RF    = wr_en_q;
  assign bus.WRITE_INDEX_RF = wr_idx_q;
  assign bus.WRITE_DATA_RF  = wr_dat_q;
  assign bus.RETIRED_CNT    = retired_q;

endmodule
